rf_wr_arbiter: RTL and testbench

Arbiter for the single register-file write port, shared between the in-order W stage and a long-latency unit (LU: iterative mul/div, or a late load return) that completes out of band. The W stage has priority. An LU that keeps losing arbitration is protected by a starvation counter: at the limit, the arbiter stalls W for one cycle and gives the port to the LU. All register-file write-port signals are registered.

---
 rtl/rf_wr_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: the W stage has priority, and a starvation counter
// forces a one-cycle W stall so the long-latency unit (LU) gets the port.
module rf_wr_arbiter #(
  parameter int unsigned N_BITS       = 32,
  parameter int unsigned ADDR_BITS    = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_vld,
  input  logic                 w_wen,
  input  logic [ADDR_BITS-1:0] w_waddr,
  input  logic [N_BITS-1:0]    w_wdata,
  output logic                 w_stall,
  input  logic                 lu_req,
  input  logic [ADDR_BITS-1:0] lu_waddr,
  input  logic [N_BITS-1:0]    lu_wdata,
  output logic                 lu_gnt,
  output logic                 rf_wen,
  output logic [ADDR_BITS-1:0] rf_waddr,
  output logic [N_BITS-1:0]    rf_wdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    PIPE  = 1'b0,
    FORCE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   w_act;
  logic                   sel_w, sel_lu;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic [N_BITS-1:0]      sel_data;
  logic                   rf_wen_q, rf_wen_d;
  logic [ADDR_BITS-1:0]   rf_waddr_q, rf_waddr_d;
  logic [N_BITS-1:0]      rf_wdata_q, rf_wdata_d;

  // Writes to x0 never occupy the port.
  assign w_act = w_vld && w_wen && (w_waddr != '0);

  always_comb begin
    state_d = PIPE;
    cnt_d   = '0;
    cnt_inc = cnt_q + 1'b1;
    lu_gnt  = 1'b0;
    sel_w   = 1'b0;
    sel_lu  = 1'b0;
    case (state_q)
      PIPE: begin
        lu_gnt = lu_req && !w_act;
        sel_w  = w_act;
        sel_lu = lu_req && !w_act;
        // A denied LU request counts toward starvation; any grant or withdrawal clears it.
        if (lu_req && w_act) begin
          if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
            state_d = FORCE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      FORCE: begin
        lu_gnt = lu_req;
        sel_lu = lu_req;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_addr   = sel_w ? w_waddr : lu_waddr;
    sel_data   = sel_w ? w_wdata : lu_wdata;
    rf_wen_d   = (sel_w || sel_lu) && (sel_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (sel_w || sel_lu) begin
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PIPE;
      cnt_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Pure state decode keeps the stall free of any input-to-output path.
  assign w_stall  = (state_q == FORCE);
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the arbitration rules.
module tb_rf_wr_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_vld, w_wen;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;
  logic        w_stall;
  logic        lu_req;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_gnt;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  rf_wr_arbiter #(.N_BITS(32), .ADDR_BITS(5), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_vld(w_vld), .w_wen(w_wen), .w_waddr(w_waddr), .w_wdata(w_wdata),
    .w_stall(w_stall),
    .lu_req(lu_req), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_gnt(lu_gnt),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "is the next cycle a forced LU cycle", consecutive denials of the
  // outstanding LU request, and the expected contents of the registered write port.
  bit        m_force;
  int        m_deny;
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;

  function automatic bit w_wants();
    return w_vld && w_wen && (w_waddr != 5'd0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_force <= 1'b0;
      m_deny  <= 0;
      m_wen   <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
    end else if (m_force) begin
      m_force <= 1'b0;
      m_deny  <= 0;
      m_wen   <= lu_req && (lu_waddr != 5'd0);
      if (lu_req) begin
        m_waddr <= lu_waddr;
        m_wdata <= lu_wdata;
      end
    end else if (w_wants()) begin
      m_wen   <= 1'b1;
      m_waddr <= w_waddr;
      m_wdata <= w_wdata;
      if (lu_req && (m_deny + 1 == LIMIT)) begin
        m_force <= 1'b1;
        m_deny  <= 0;
      end else if (lu_req) begin
        m_deny <= m_deny + 1;
      end else begin
        m_deny <= 0;
      end
    end else begin
      m_deny <= 0;
      m_wen  <= lu_req && (lu_waddr != 5'd0);
      if (lu_req) begin
        m_waddr <= lu_waddr;
        m_wdata <= lu_wdata;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_lu_gnt", lu_gnt, m_force ? lu_req : (lu_req && !w_wants()));
    chk("model_w_stall", w_stall, m_force);
    chk("model_rf_wen", rf_wen, m_wen);
    chk("model_rf_waddr", rf_waddr, m_waddr);
    chk("model_rf_wdata", rf_wdata, m_wdata);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic w_idle();
    w_vld = 0; w_wen = 0; w_waddr = '0; w_wdata = '0;
  endtask

  task automatic drive_w(input logic [4:0] a, input logic [31:0] d);
    w_vld = 1; w_wen = 1; w_waddr = a; w_wdata = d;
  endtask

  task automatic drive_lu(input logic r, input logic [4:0] a, input logic [31:0] d);
    lu_req = r; lu_waddr = a; lu_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit granted;
    // Reset with random W inputs and no LU request.
    rst_n = 0;
    w_vld = 1; w_wen = 1; w_waddr = 5'd9; w_wdata = $urandom;
    drive_lu(0, 5'd3, $urandom);
    @(negedge clk);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_w_stall", w_stall, 0);
    chk("rst_lu_gnt", lu_gnt, 0);
    next_cycle();
    rst_n = 1;
    w_idle();

    // W only.
    next_cycle();
    drive_w(5'd5, 32'hDEADBEEF);
    drive_lu(0, 5'd0, 32'h0);
    @(negedge clk);
    chk("wonly_lu_gnt", lu_gnt, 0);
    next_cycle();
    w_idle();
    @(negedge clk);
    chk("wonly_rf_wen", rf_wen, 1);
    chk("wonly_rf_waddr", rf_waddr, 5);
    chk("wonly_rf_wdata", rf_wdata, 32'hDEADBEEF);

    // LU only.
    next_cycle();
    drive_lu(1, 5'd7, 32'h00001234);
    @(negedge clk);
    chk("luonly_lu_gnt", lu_gnt, 1);
    next_cycle();
    drive_lu(0, 5'd0, 32'h0);
    @(negedge clk);
    chk("luonly_rf_wen", rf_wen, 1);
    chk("luonly_rf_waddr", rf_waddr, 7);
    chk("luonly_rf_wdata", rf_wdata, 32'h00001234);

    // W to x0 does not block the LU.
    next_cycle();
    drive_w(5'd0, 32'h55555555);
    drive_lu(1, 5'd8, 32'hCAFE0008);
    @(negedge clk);
    chk("x0w_lu_gnt", lu_gnt, 1);
    next_cycle();
    w_idle();
    drive_lu(1, 5'd0, 32'h0BAD0000);
    @(negedge clk);
    chk("x0w_rf_wen", rf_wen, 1);
    chk("x0w_rf_waddr", rf_waddr, 8);
    chk("x0lu_lu_gnt", lu_gnt, 1);
    next_cycle();
    drive_lu(0, 5'd0, 32'h0);
    @(negedge clk);
    chk("x0lu_rf_wen", rf_wen, 0);

    // Starvation: continuous W contention, LU request held until granted.
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (c < 5) drive_w(5'(3 + c), 32'hA0000000 + c);
      else w_idle();
      drive_lu(c < 5, 5'd12, 32'h0000C0DE);
      @(negedge clk);
      if (c < 4) begin
        chk("starve_lu_gnt_low", lu_gnt, 0);
        chk("starve_w_stall_low", w_stall, 0);
      end
      if (c >= 1 && c <= 4) chk("starve_rf_waddr_w", rf_waddr, 5'(3 + c - 1));
      if (c == 4) begin
        chk("starve_force_stall", w_stall, 1);
        chk("starve_force_gnt", lu_gnt, 1);
      end
      if (c == 5) begin
        chk("starve_rf_waddr_lu", rf_waddr, 12);
        chk("starve_rf_wdata_lu", rf_wdata, 32'h0000C0DE);
        chk("starve_stall_released", w_stall, 0);
      end
    end

    // Reset during FORCE, then a fresh contention needs the full denial count again.
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive_w(5'(3 + c), $urandom);
      drive_lu(1, 5'd12, 32'h0000BEEF);
    end
    next_cycle();
    #1;
    chk("midforce_stall_before", w_stall, 1);
    w_idle();
    drive_lu(0, 5'd12, 32'h0000BEEF);
    rst_n = 0;
    #1;
    chk("midforce_stall_async", w_stall, 0);
    chk("midforce_rf_wen_async", rf_wen, 0);
    chk("midforce_rf_waddr_async", rf_waddr, 0);
    next_cycle();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      drive_w(5'(10 + c), $urandom);
      drive_lu(1, 5'd20, 32'h00002020);
      @(negedge clk);
      if (c < 4) chk("postrst_deny_stall", w_stall, 0);
      else chk("postrst_force_stall", w_stall, 1);
    end
    next_cycle();
    w_idle();
    drive_lu(0, 5'd0, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      granted = lu_req && lu_gnt;
      next_cycle();
      if (!lu_req || granted) begin
        lu_req   = ($urandom_range(0, 3) != 0);
        lu_waddr = 5'($urandom_range(0, 31));
        lu_wdata = $urandom;
      end else if ($urandom_range(0, 63) == 0) begin
        lu_req = 0;
      end
      w_vld   = ($urandom_range(0, 7) != 0);
      w_wen   = ($urandom_range(0, 3) != 0);
      w_waddr = 5'($urandom_range(0, 31));
      w_wdata = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
    end

    next_cycle();
    w_idle();
    drive_lu(0, 5'd0, 32'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
